// File: rtl/soft_expander.sv
// soft_expander: piecewise-linear soft expander for the sample path.
//   Small inputs pass at unity gain. Each higher segment of |x| adds one
//   quarter-gain step. The output saturates at full scale.
//   mode=0 is bypass with 1 clk latency.
//   mode=1 is expand: the slope*fraction product comes from a serial LSB-first
//   shift-add multiplier, so strobe-to-output is FW+2 clk.
//   Strobes that arrive while busy is high are dropped.
// Build option: define SOFT_EXPANDER_ROUND_EN to round half up before the
//   final >>2. When it is undefined the result is truncated.
// Handshake: there is no backpressure. A sampleClk pulse is accepted only when
//   busy=0, i.e. sampleClk acts as "valid" and ~busy acts as "ready". A pulse
//   with busy=1 is lost.
// dbg_state exposes the FSM state (IDLE/MUL/OUT) for checkers.
module soft_expander #(
  parameter int SIGWIDTH = 8,
  parameter int SEGBITS  = 4
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic                       sampleClk,
  input  logic                       mode,
  input  logic signed [SIGWIDTH-1:0] sampleIn,
  output logic signed [SIGWIDTH-1:0] sampleOut,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int FW      = SIGWIDTH - 1 - SEGBITS;
  localparam int W       = 2 ** FW;
  localparam int KMAX    = 2 ** SEGBITS - 1;
  localparam int SMAX    = 4 + KMAX;
  localparam int BMAX    = W * (4 * KMAX + KMAX * (KMAX - 1) / 2);
  localparam int ACC_MAX = BMAX + SMAX * (W - 1);
  // One spare bit so that the +2 rounding offset can never wrap.
  localparam int ACCW    = $clog2(ACC_MAX + 1) + 1;
  localparam int SW      = $clog2(SMAX + 1);
  localparam int CW      = (FW > 1) ? $clog2(FW) : 1;
  localparam int MAXPOS  = 2 ** (SIGWIDTH - 1) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                sign_q;
  logic [SEGBITS-1:0]  k_q;
  logic [FW-1:0]       f_q;
  logic [CW-1:0]       step_q;
  logic [ACCW-1:0]     prod_q;

  logic [SIGWIDTH-1:0] neg_in;
  logic [SIGWIDTH-2:0] mag;
  logic [SW-1:0]       slope;
  logic [ACCW-1:0]     acc;
  logic [ACCW-1:0]     acc_r;
  logic [ACCW-1:0]     y_full;
  logic [SIGWIDTH-1:0] y_sat;

  // Segment base B_k in quarter-gain units. It depends only on k.
  function automatic logic [ACCW-1:0] base_of(input logic [SEGBITS-1:0] k);
    int ki;
    ki = int'(k);
    return ACCW'(W * (4 * ki + ki * (ki - 1) / 2));
  endfunction

  assign dbg_state = state;

  // Input magnitude. -full-scale has no positive twin, so it clamps to MAXPOS.
  always_comb begin
    neg_in = SIGWIDTH'(~sampleIn) + SIGWIDTH'(1);
    mag    = sampleIn[SIGWIDTH-1] ? neg_in[SIGWIDTH-2:0] : sampleIn[SIGWIDTH-2:0];
    if (sampleIn[SIGWIDTH-1] && neg_in[SIGWIDTH-1]) begin
      mag = '1;
    end
  end

  // Result formation: base plus product, optional rounding, then saturation.
  always_comb begin
    slope  = SW'(4) + SW'(k_q);
    acc    = base_of(k_q) + prod_q;
`ifdef SOFT_EXPANDER_ROUND_EN
    acc_r  = acc + ACCW'(2);
`else
    acc_r  = acc;
`endif
    y_full = acc_r >> 2;
    if (y_full > ACCW'(MAXPOS)) begin
      y_sat = SIGWIDTH'(MAXPOS);
    end else begin
      y_sat = y_full[SIGWIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state. Only an expand strobe accepted in IDLE leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sampleClk && mode) state_nxt = MUL;
      MUL:  if (step_q == CW'(FW - 1)) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, one shift-add step per MUL cycle, write result in OUT.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sign_q    <= 1'b0;
      k_q       <= '0;
      f_q       <= '0;
      step_q    <= '0;
      prod_q    <= '0;
      sampleOut <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sampleClk) begin
            if (mode) begin
              sign_q <= sampleIn[SIGWIDTH-1];
              k_q    <= mag[SIGWIDTH-2 -: SEGBITS];
              f_q    <= mag[FW-1:0];
              step_q <= '0;
              prod_q <= '0;
              busy   <= 1'b1;
            end else begin
              sampleOut <= sampleIn;
            end
          end
        end
        MUL: begin
          if (f_q[0]) begin
            prod_q <= prod_q + (ACCW'(slope) << step_q);
          end
          f_q    <= f_q >> 1;
          step_q <= step_q + CW'(1);
        end
        OUT: begin
          sampleOut <= sign_q ? SIGWIDTH'(-y_sat) : y_sat;
          busy      <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_soft_expander.sv
// tb_soft_expander: directed and randomized bench for soft_expander
// (SIGWIDTH=8, SEGBITS=4). Honours SOFT_EXPANDER_ROUND_EN in its reference model.
module tb_soft_expander;

  localparam int FWB    = 3;
  localparam int WB     = 8;
  localparam int MAXPOS = 127;
  localparam int EXP_LAT = FWB + 2;

  logic              clk;
  logic              nReset;
  logic              sampleClk;
  logic              mode;
  logic signed [7:0] sampleIn;
  logic signed [7:0] sampleOut;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  soft_expander #(.SIGWIDTH(8), .SEGBITS(4)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .sampleClk (sampleClk),
    .mode      (mode),
    .sampleIn  (sampleIn),
    .sampleOut (sampleOut),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference model written straight from the segment/slope rules
  function automatic logic [7:0] model(input logic [7:0] x, input logic m);
    int xi, mag, k, f, acc, y;
    if (!m) return x;
    xi  = int'($signed(x));
    mag = (xi < 0) ? -xi : xi;
    if (mag > MAXPOS) mag = MAXPOS;
    k   = mag / WB;
    f   = mag % WB;
    acc = WB * (4 * k + k * (k - 1) / 2) + (4 + k) * f;
`ifdef SOFT_EXPANDER_ROUND_EN
    y   = (acc + 2) / 4;
`else
    y   = acc / 4;
`endif
    if (y > MAXPOS) y = MAXPOS;
    return (xi < 0) ? 8'(-y) : 8'(y);
  endfunction

  // Driver: a one-cycle strobe. Returns at the negedge after the strobe edge.
  task automatic drive_strobe(input logic [7:0] x, input logic m);
    @(negedge clk);
    sampleIn  = x;
    mode      = m;
    sampleClk = 1'b1;
    @(negedge clk);
    sampleClk = 1'b0;
  endtask

  // Driver: expand strobe. Returns the output and the clk count until busy drops.
  task automatic expand_sample(input logic [7:0] x, output logic [7:0] y, output int lat);
    drive_strobe(x, 1'b1);
    lat = 1;
    while (busy === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y = sampleOut;
  endtask

  task automatic test_reset();
    nReset = 1'b0; sampleClk = 1'b0; mode = 1'b0; sampleIn = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sampleOut !== 8'sd0) begin
      errors++; $display("FAIL reset_out got %0d exp 0", sampleOut);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    logic busy_seen;
    drive_strobe(8'(-37), 1'b0);
    busy_seen = busy;
    checks++;
    if (sampleOut !== -8'sd37) begin
      errors++; $display("FAIL bypass_out got %0d exp -37", sampleOut);
    end
    repeat (3) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++; $display("FAIL bypass_busy got %b exp 0", busy_seen);
    end
  endtask

  task automatic test_expand_basic();
    logic [7:0] xs[3];
    logic [7:0] es[3];
    logic [7:0] y;
    int lat;
    xs[0] = 8'd0;  es[0] = 8'd0;
    xs[1] = 8'd5;  es[1] = 8'd5;
    xs[2] = 8'(-20); es[2] = 8'(-24);
    for (int i = 0; i < 3; i++) begin
      expand_sample(xs[i], y, lat);
      checks++;
      if (y !== es[i]) begin
        errors++; $display("FAIL expand_out[%0d] got %0d exp %0d", i, $signed(y), $signed(es[i]));
      end
      checks++;
      if (lat != EXP_LAT) begin
        errors++; $display("FAIL expand_latency[%0d] got %0d exp %0d", i, lat, EXP_LAT);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] y;
    int lat;
    expand_sample(8'd100, y, lat);
    checks++;
    if (y !== 8'd127) begin
      errors++; $display("FAIL sat_pos got %0d exp 127", $signed(y));
    end
    expand_sample(8'h80, y, lat);
    checks++;
    if (y !== 8'(-127)) begin
      errors++; $display("FAIL sat_neg got %0d exp -127", $signed(y));
    end
  endtask

  task automatic test_rounding();
    logic [7:0] y;
    logic [7:0] e;
    int lat;
`ifdef SOFT_EXPANDER_ROUND_EN
    e = 8'd11;
`else
    e = 8'd10;
`endif
    expand_sample(8'd10, y, lat);
    checks++;
    if (y !== e) begin
      errors++; $display("FAIL round_10 got %0d exp %0d", $signed(y), $signed(e));
    end
  endtask

  task automatic test_hold();
    logic [7:0] y;
    int lat;
    expand_sample(8'(-20), y, lat);
    // Input changes without a strobe must not reach the output.
    mode = 1'b0; sampleIn = 8'sd99;
    repeat (4) @(negedge clk);
    checks++;
    if (sampleOut !== -8'sd24) begin
      errors++; $display("FAIL hold_out got %0d exp -24", sampleOut);
    end
  endtask

  task automatic test_drop_while_busy();
    logic [7:0] y;
    int lat;
    drive_strobe(8'd5, 1'b1);
    @(negedge clk);
    sampleIn = 8'd100; mode = 1'b1; sampleClk = 1'b1;
    @(negedge clk);
    sampleClk = 1'b0;
    lat = 0;
    while (busy === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sampleOut !== 8'sd5) begin
      errors++; $display("FAIL drop_out got %0d exp 5", sampleOut);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_busy got %b exp 0", busy);
    end
    expand_sample(8'(-20), y, lat);
    checks++;
    if (y !== 8'(-24) || lat != EXP_LAT) begin
      errors++; $display("FAIL drop_next got %0d lat %0d exp -24 lat %0d", $signed(y), lat, EXP_LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] y;
    int lat;
    drive_strobe(8'(-37), 1'b0);
    drive_strobe(8'd100, 1'b1);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    checks++;
    if (sampleOut !== 8'sd0) begin
      errors++; $display("FAIL rstmid_out got %0d exp 0", sampleOut);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy got %b exp 0", busy);
    end
    @(negedge clk);
    nReset = 1'b1;
    repeat (FWB + 3) @(negedge clk);
    checks++;
    if (sampleOut !== 8'sd0) begin
      errors++; $display("FAIL rstmid_nopartial got %0d exp 0", sampleOut);
    end
    expand_sample(8'd5, y, lat);
    checks++;
    if (y !== 8'd5 || lat != EXP_LAT) begin
      errors++; $display("FAIL rstmid_fresh got %0d lat %0d exp 5 lat %0d", $signed(y), lat, EXP_LAT);
    end
  endtask

  task automatic test_random();
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] e;
    logic m;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      exp_q.push_back(model(x, m));
      if (m) begin
        expand_sample(x, y, lat);
      end else begin
        drive_strobe(x, 1'b0);
        lat = 1;
        y = sampleOut;
      end
      e = exp_q.pop_front();
      checks++;
      if (y !== e) begin
        errors++; $display("FAIL rand[%0d] in %0d mode %b got %0d exp %0d", i, $signed(x), m, $signed(y), $signed(e));
      end
      checks++;
      if (lat != (m ? EXP_LAT : 1)) begin
        errors++; $display("FAIL rand_lat[%0d] got %0d exp %0d", i, lat, m ? EXP_LAT : 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_expand_basic();
    test_saturation();
    test_rounding();
    test_hold();
    test_drop_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
